// File: rtl/cv32e40p_x_wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and X-interface results.
// Queued X-results keep write-after-write order against WB writes and cannot starve.
module cv32e40p_x_wb_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_we_i,
  input  logic [4:0]  core_waddr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_wb_stall_o,
  input  logic        x_result_valid_i,
  output logic        x_result_ready_o,
  input  logic [4:0]  x_result_rd_i,
  input  logic [31:0] x_result_data_i,
  input  logic        x_result_we_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        sb_clr_valid_o,
  output logic [4:0]  sb_clr_rd_o,
  output logic [3:0]  pending_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q;
  logic [WW-1:0]    wait_q;

  logic accept, x_wr, nonempty, haz;
  logic push, pop, wait_inc;

  assign x_result_ready_o = (count_q != CW'(DEPTH));
  assign accept           = x_result_valid_i & x_result_ready_o;
  assign x_wr             = accept & x_result_we_i & (x_result_rd_i != 5'd0);
  assign nonempty         = (count_q != '0);
  assign pending_o        = 4'(count_q);

  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_q[i] == core_waddr_i)) haz = 1'b1;
    end
    haz = haz & core_we_i;
  end

  always_comb begin
    rf_we_o         = 1'b0;
    rf_waddr_o      = '0;
    rf_wdata_o      = '0;
    sb_clr_valid_o  = 1'b0;
    sb_clr_rd_o     = '0;
    core_wb_stall_o = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    wait_inc        = 1'b0;
    if (nonempty && ((wait_q == WW'(MAX_WAIT)) || haz || !core_we_i)) begin
      pop             = 1'b1;
      rf_we_o         = 1'b1;
      rf_waddr_o      = rd_q[rptr_q];
      rf_wdata_o      = data_q[rptr_q];
      sb_clr_valid_o  = 1'b1;
      sb_clr_rd_o     = rd_q[rptr_q];
      core_wb_stall_o = core_we_i;
      push            = x_wr;
    end else if (core_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = core_waddr_i;
      rf_wdata_o = core_wdata_i;
      push       = x_wr;
      wait_inc   = nonempty;
    end else if (x_wr) begin
      // empty FIFO and idle core: write the X-result straight through
      rf_we_o        = 1'b1;
      rf_waddr_o     = x_result_rd_i;
      rf_wdata_o     = x_result_data_i;
      sb_clr_valid_o = 1'b1;
      sb_clr_rd_o    = x_result_rd_i;
    end
  end

  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[rptr_q] = 1'b0;
    if (push) vld_d[wptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (pop)  rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      if (push) wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (pop || !nonempty)                         wait_q <= '0;
      else if (wait_inc && wait_q != WW'(MAX_WAIT)) wait_q <= wait_q + WW'(1);
    end
  end

  // entry payload needs no reset: validity is tracked by vld_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[wptr_q]   <= x_result_rd_i;
      data_q[wptr_q] <= x_result_data_i;
    end
  end

endmodule

// File: tb/tb_cv32e40p_x_wb_arbiter.sv
// Randomized scoreboard bench for cv32e40p_x_wb_arbiter with a queue-based reference model.
module tb_cv32e40p_x_wb_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_we_i = 1'b0;
  logic [4:0]  core_waddr_i = '0;
  logic [31:0] core_wdata_i = '0;
  logic        core_wb_stall_o;
  logic        x_result_valid_i = 1'b0;
  logic        x_result_ready_o;
  logic [4:0]  x_result_rd_i = '0;
  logic [31:0] x_result_data_i = '0;
  logic        x_result_we_i = 1'b0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        sb_clr_valid_o;
  logic [4:0]  sb_clr_rd_o;
  logic [3:0]  pending_o;

  cv32e40p_x_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_we_i(core_we_i), .core_waddr_i(core_waddr_i), .core_wdata_i(core_wdata_i),
    .core_wb_stall_o(core_wb_stall_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_rd_i(x_result_rd_i), .x_result_data_i(x_result_data_i), .x_result_we_i(x_result_we_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .sb_clr_valid_o(sb_clr_valid_o), .sb_clr_rd_o(sb_clr_rd_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  typedef struct {
    bit we; logic [4:0] a; logic [31:0] d; bit clr; logic [4:0] crd;
    bit stall; bit rdy; int pend;
  } exp_t;

  ent_t fq[$];
  exp_t eq[$];
  int   wq = 0;
  int   total = 0, passed = 0;
  bit   last_stall = 0, last_acc = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, derive the expected response from the model, advance the model.
  task automatic step(input bit cwe, input logic [4:0] ca, input logic [31:0] cd,
                      input bit xv, input logic [4:0] xr, input logic [31:0] xd, input bit xw);
    exp_t e;
    bit   wr, haz;
    @(posedge clk_i); #1;
    core_we_i = cwe; core_waddr_i = ca; core_wdata_i = cd;
    x_result_valid_i = xv; x_result_rd_i = xr; x_result_data_i = xd; x_result_we_i = xw;
    e = '{default: '0};
    e.pend = fq.size();
    e.rdy  = (fq.size() != DEPTH);
    wr  = xv && e.rdy && xw && (xr != 0);
    haz = 0;
    foreach (fq[i]) if (cwe && fq[i].rd == ca) haz = 1;
    if (fq.size() > 0 && (wq == MAX_WAIT || haz || !cwe)) begin
      e.we = 1; e.a = fq[0].rd; e.d = fq[0].data; e.clr = 1; e.crd = fq[0].rd; e.stall = cwe;
      void'(fq.pop_front());
      wq = 0;
      if (wr) fq.push_back('{xr, xd});
    end else if (cwe) begin
      e.we = 1; e.a = ca; e.d = cd;
      wq = (fq.size() > 0) ? wq + 1 : 0;
      if (wr) fq.push_back('{xr, xd});
    end else begin
      wq = 0;
      if (wr) begin e.we = 1; e.a = xr; e.d = xd; e.clr = 1; e.crd = xr; end
    end
    last_stall = e.stall;
    last_acc   = xv && e.rdy;
    eq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    core_we_i = 0; x_result_valid_i = 0;
    rst_ni = 0;
    fq.delete(); wq = 0; last_stall = 0; last_acc = 0;
    #2;
    chk("rst_pending", pending_o, 0);
    chk("rst_ready", x_result_ready_o, 1);
    chk("rst_sbclr", sb_clr_valid_o, 0);
    @(negedge clk_i); rst_ni = 1;
  endtask

  always @(negedge clk_i) begin
    if (eq.size() > 0) begin
      exp_t e;
      e = eq.pop_front();
      chk("rf_we", rf_we_o, e.we);
      chk("stall", core_wb_stall_o, e.stall);
      chk("ready", x_result_ready_o, e.rdy);
      chk("pending", pending_o, e.pend);
      chk("sb_clr", sb_clr_valid_o, e.clr);
      if (e.we) begin
        chk("rf_waddr", rf_waddr_o, e.a);
        chk("rf_wdata", rf_wdata_o, e.d);
      end
      if (e.clr) chk("sb_clr_rd", sb_clr_rd_o, e.crd);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #2;
    chk("reset_ready", x_result_ready_o, 1);
    chk("reset_pending", pending_o, 0);
    chk("reset_rf_we", rf_we_o, 0);
    @(negedge clk_i); rst_ni = 1;

    // bypass with idle core
    step(0, 0, 0, 1, 5, 32'hA5A5_0001, 1); #1;
    chk("bypass_addr", rf_waddr_o, 5);
    chk("bypass_data", rf_wdata_o, 32'hA5A5_0001);
    chk("bypass_sbrd", sb_clr_rd_o, 5);
    chk("bypass_pend", pending_o, 0);

    // starvation bound with core held on x3
    step(1, 3, 32'h33, 1, 7, 32'h77, 1);
    step(1, 3, 32'h33, 1, 8, 32'h88, 1);
    step(1, 3, 32'h33, 0, 0, 0, 0); #1;
    chk("full_ready", x_result_ready_o, 0);
    for (int k = 0; k < 2; k++) begin
      step(1, 3, 32'h33, 0, 0, 0, 0); #1;
      chk("starve_core_wins", core_wb_stall_o, 0);
    end
    step(1, 3, 32'h33, 0, 0, 0, 0); #1;
    chk("starve_stall", core_wb_stall_o, 1);
    chk("starve_addr", rf_waddr_o, 7);
    idle(3);

    // WAW hazard on x9
    step(1, 3, 32'h33, 1, 9, 32'h9999_0000, 1);
    step(1, 9, 32'h9999_0001, 0, 0, 0, 0); #1;
    chk("haz_stall", core_wb_stall_o, 1);
    chk("haz_old_data", rf_wdata_o, 32'h9999_0000);
    step(1, 9, 32'h9999_0001, 0, 0, 0, 0); #1;
    chk("haz_release", core_wb_stall_o, 0);
    chk("haz_new_data", rf_wdata_o, 32'h9999_0001);

    // non-writing results are consumed silently
    step(0, 0, 0, 1, 4, 32'h44, 0); #1;
    chk("nowe_ready", x_result_ready_o, 1);
    chk("nowe_rf_we", rf_we_o, 0);
    step(0, 0, 0, 1, 0, 32'h55, 1); #1;
    chk("rd0_rf_we", rf_we_o, 0);
    chk("rd0_sbclr", sb_clr_valid_o, 0);

    // full FIFO, core idle, new result waits one cycle
    step(1, 3, 32'h33, 1, 7, 32'h70, 1);
    step(1, 3, 32'h33, 1, 8, 32'h80, 1);
    step(0, 0, 0, 1, 10, 32'hA0, 1); #1;
    chk("fullpop_ready", x_result_ready_o, 0);
    chk("fullpop_addr", rf_waddr_o, 7);
    step(0, 0, 0, 1, 10, 32'hA0, 1); #1;
    chk("fullpop_ready_next", x_result_ready_o, 1);
    idle(3);

    // reset with two pending entries
    step(1, 3, 32'h33, 1, 11, 32'hB0, 1);
    step(1, 3, 32'h33, 1, 12, 32'hC0, 1);
    do_reset();
    idle(4);

    // randomized traffic honouring valid/ready and WB hold
    for (int i = 0; i < 3000; i++) begin
      bit cwe, xv, xw;
      logic [4:0] ca, xr;
      logic [31:0] cd, xd;
      if (i == 1500) do_reset();
      if (last_stall) begin
        cwe = core_we_i; ca = core_waddr_i; cd = core_wdata_i;
      end else begin
        cwe = ($urandom_range(0, 9) < 6); ca = 5'($urandom_range(0, 7)); cd = $urandom;
      end
      if (x_result_valid_i && !last_acc) begin
        xv = 1; xr = x_result_rd_i; xd = x_result_data_i; xw = x_result_we_i;
      end else begin
        xv = ($urandom_range(0, 1) == 1); xr = 5'($urandom_range(0, 7));
        xd = $urandom; xw = ($urandom_range(0, 3) != 0);
      end
      step(cwe, ca, cd, xv, xr, xd, xw);
    end
    idle(10);
    @(posedge clk_i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cv32e40p_x_wb_arbiter.md
# cv32e40p_x_wb_arbiter

Arbitrates the single register-file write port of cv32e40p between the core's writeback (WB) stage and results returning over the X-interface result channel. Accepted X-results either write through in the same cycle or wait in a small result FIFO. The block keeps write-after-write order against WB-stage writes and prevents starvation of queued X-results. Sits between the WB stage, the X-interface dispatcher (scoreboard clear) and the register file.

## Interface
- DEPTH, 2: result FIFO entries; legal values 1–8.
- MAX_WAIT, 4: maximum consecutive cycles a non-empty FIFO may lose the port to core writes; must be ≥1.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_we_i  in  1  WB stage requests a write
- core_waddr_i  in  5  WB write address
- core_wdata_i  in  32  WB write data
- core_wb_stall_o  out  1  WB write not performed this cycle; WB must hold its inputs stable
- x_result_valid_i  in  1  X-result valid
- x_result_ready_o  out  1  X-result accepted when valid and ready
- x_result_rd_i  in  5  X-result destination register
- x_result_data_i  in  32  X-result data
- x_result_we_i  in  1  X-result requests a register write
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- sb_clr_valid_o  out  1  pulse: an X-result has been written and its scoreboard bit is cleared
- sb_clr_rd_o  out  5  register whose scoreboard bit is cleared
- pending_o  out  4  FIFO occupancy

## Operation
- FIFO entries hold {rd, data}. Occupancy counter ranges 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- x_result_ready_o = (count != DEPTH). It depends only on registered state; there is no same-cycle pop-to-ready path.
- A result accepted with x_result_we_i=0, or with rd=0, is consumed. It is never enqueued, never written, and never raises sb_clr.
- Hazard flag haz = core_we_i and core_waddr_i equals the rd of any valid FIFO entry.
- Wait counter wait_q counts 0..MAX_WAIT. It increments each cycle the FIFO is non-empty and the core write wins the port. It clears on every FIFO pop and whenever the FIFO is empty.
- Port selection, evaluated each cycle in this priority order:
  1. FIFO non-empty and (wait_q==MAX_WAIT or haz or ~core_we_i): pop the head to the RF. core_wb_stall_o = core_we_i.
  2. Otherwise, if core_we_i: write the core data and set core_wb_stall_o=0. An accepted writable X-result is enqueued.
  3. Otherwise (FIFO empty, no core write): an accepted writable X-result bypasses the FIFO and is written the same cycle.
- Under cases 1 and 2, an accepted writable X-result is enqueued. A simultaneous push and pop leaves count unchanged.
- sb_clr_valid_o / sb_clr_rd_o are asserted on exactly the cycle an X-result is driven to the RF, whether popped or bypassed.
- A core write with core_waddr_i=0 is passed through unchanged; the RF ignores x0.

## Timing
- Reset values: count=0, wait_q=0, pointers=0. Therefore x_result_ready_o=1, pending_o=0, and rf_we_o, core_wb_stall_o and sb_clr_valid_o are all 0 while inputs are idle.
- All rf_* and stall outputs are combinational from the current inputs and registered state. The RF writes on the next clk_i edge.
- Latency: bypass is 0 cycles from acceptance to RF write. A queued result is written no later than MAX_WAIT cycles after it reaches the FIFO head.
- During a hazard stall, the FIFO drains one entry per cycle until no matching entry remains. The core write then proceeds, so the newer core value lands last.
- Full FIFO: ready is low and valid must be held (standard valid/ready). A pop while full raises ready in the next cycle.
- Reset asserted mid-operation discards all FIFO contents; no sb_clr is issued for discarded entries.
- The stall output is asserted in the same cycle as core_we_i and stays asserted for each cycle the port is taken.

## Test plan
- Idle core, X-result rd=5, data=0xA5A5_0001 -> same cycle: rf_we_o=1, rf_waddr_o=5, sb_clr_valid_o=1 with sb_clr_rd_o=5; pending_o stays 0.
- core_we_i held high to rd=3 (no hazard), X-results rd=7 then rd=8, DEPTH=2 -> both enqueued, then ready=0. With MAX_WAIT=4, four core writes occur, then core_wb_stall_o=1 and rd=7 is written.
- Core write rd=9 while the FIFO holds rd=9 (older) -> core_wb_stall_o=1 for one cycle, FIFO rd=9 written first, core rd=9 written in the next cycle.
- X-results with x_result_we_i=0, and with rd=0 -> accepted (ready=1), rf_we_o=0, sb_clr_valid_o=0, pending_o unchanged.
- FIFO full, core idle, new valid result -> pop head and ready=0 in the same cycle; ready=1 in the next cycle, then the new result is enqueued.
- Assert rst_ni low with pending_o=2 -> pending_o=0, x_result_ready_o=1, no sb_clr pulses after release.
